// File: rtl/relm_div_pkg.sv
// Shared types and sub-op constants for the relm_custom iterative divide sequencer.
package relm_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIV  = 3'd1,
    ST_INIT = 3'd2,
    ST_LOOP = 3'd3,
    ST_MOD  = 3'd4,
    ST_DONE = 3'd5
  } div_state_e;

  // Custom-unit opcode (low bits of op_in) and divide sub-ops carried in x_in.
  localparam logic [2:0] DIV_OP    = 3'b101;
  localparam logic [1:0] X_DIVINIT = 2'b10;
  localparam logic [1:0] X_DIVLOOP = 2'b01;
  localparam logic [1:0] X_DIVMOD  = 2'b11;

endpackage

// File: rtl/relm_onehot_log2.sv
// Index of the set bit of a one-hot word; an all-zero word maps to index 0.
module relm_onehot_log2 #(
  parameter int WD = 32,
  parameter int LW = $clog2(WD)
) (
  input  logic [WD-1:0] onehot_i,
  output logic [LW-1:0] idx_o
);

  // OR together the indices of all set bits (exactly one for a valid one-hot input).
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WD; i++) begin
      if (onehot_i[i]) idx_o = idx_o | LW'(i);
    end
  end

endmodule

// File: rtl/relm_div_sequencer.sv
// Sequencer driving the shared relm_custom unit through DIV, DIVINIT, DIVLOOP and
// DIVMOD steps for one unsigned N/D request. The cb bus is {D, C, B}, each field WD
// bits wide, so WC is expected to equal 2*WD.
module relm_div_sequencer
  import relm_div_pkg::*;
#(
  parameter int WD  = 32,
  parameter int WOP = 5,
  parameter int WC  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WD-1:0]    req_n,
  input  logic [WD-1:0]    req_d,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WD-1:0]    res_q,
  output logic [WD-1:0]    res_r,
  output logic             res_dz,
  output logic             cu_req,
  input  logic             cu_gnt,
  output logic [WOP-1:0]   cu_op,
  output logic             cu_opb,
  output logic [WD-1:0]    cu_x,
  output logic [WD-1:0]    cu_a,
  output logic [WD-1:0]    cu_xb,
  output logic [WC+WD-1:0] cu_cb,
  input  logic [WD-1:0]    cu_a_out,
  input  logic [WC+WD-1:0] cu_cb_out,
  input  logic [WD-1:0]    cu_mul_a,
  input  logic [WD-1:0]    cu_mul_x,
  output logic [2*WD-1:0]  cu_mul_ax
);

  localparam int LW = $clog2(WD);

  div_state_e        state_q;
  logic [WD-1:0]     a_q, xb_q, d_q, c_q, b_q;
  logic [WD-1:0]     quo_q, rem_q;
  logic              res_valid_q, res_dz_q, cu_req_q, req_ready_q;
  logic [WD-1:0]     out_d, out_c, out_b;
  logic [LW-1:0]     pd;

  assign out_d = cu_cb_out[WC+WD-1 -: WD];
  assign out_c = cu_cb_out[WD +: WD];
  assign out_b = cu_cb_out[WD-1:0];

  // In the DIV step the B field carries the one-hot MSB of D; pd is its position.
  relm_onehot_log2 #(.WD(WD), .LW(LW)) u_pd (
    .onehot_i (out_b),
    .idx_o    (pd)
  );

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign res_q     = quo_q;
  assign res_r     = rem_q;
  assign res_dz    = res_dz_q;
  assign cu_req    = cu_req_q;
  assign cu_op     = WOP'(DIV_OP);
  assign cu_a      = a_q;
  assign cu_cb     = {d_q, c_q, b_q};
  assign cu_xb     = (state_q == ST_DIV) ? xb_q : '0;
  assign cu_mul_ax = (2*WD)'(cu_mul_a) * (2*WD)'(cu_mul_x);

  // Sub-op select: DIV uses opb=0, the three follow-on steps use opb=1 with x[WOP+1:WOP].
  always_comb begin
    cu_opb = 1'b0;
    cu_x   = '0;
    case (state_q)
      ST_INIT: begin cu_opb = 1'b1; cu_x[WOP+1:WOP] = X_DIVINIT; end
      ST_LOOP: begin cu_opb = 1'b1; cu_x[WOP+1:WOP] = X_DIVLOOP; end
      ST_MOD:  begin cu_opb = 1'b1; cu_x[WOP+1:WOP] = X_DIVMOD;  end
      default: ;
    endcase
  end

  // Control FSM and feedback registers; every issuing state holds unless granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      xb_q        <= '0;
      d_q         <= '0;
      c_q         <= '0;
      b_q         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      res_valid_q <= 1'b0;
      res_dz_q    <= 1'b0;
      cu_req_q    <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            a_q         <= req_n;
            xb_q        <= req_d;
            req_ready_q <= 1'b0;
            if (req_d == '0) begin
              quo_q       <= '1;
              rem_q       <= req_n;
              res_dz_q    <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              res_dz_q <= 1'b0;
              cu_req_q <= 1'b1;
              state_q  <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          if (cu_gnt) begin
            d_q <= out_d;
            c_q <= out_c;
            b_q <= '0;
            // One-hot compare of MSBs: N < D in magnitude class, so the quotient is 0.
            if (cu_a_out < out_b) begin
              quo_q       <= '0;
              rem_q       <= a_q;
              res_valid_q <= 1'b1;
              cu_req_q    <= 1'b0;
              state_q     <= ST_DONE;
            end else begin
              a_q     <= cu_a_out >> pd;
              state_q <= ST_INIT;
            end
          end
        end
        ST_INIT: begin
          if (cu_gnt) begin
            a_q             <= cu_a_out;
            {d_q, c_q, b_q} <= cu_cb_out;
            state_q         <= ST_LOOP;
          end
        end
        ST_LOOP: begin
          if (cu_gnt) begin
            a_q             <= cu_a_out;
            {d_q, c_q, b_q} <= cu_cb_out;
            if (cu_a_out == '0) state_q <= ST_MOD;
          end
        end
        ST_MOD: begin
          if (cu_gnt) begin
            quo_q       <= out_b;
            rem_q       <= cu_a_out;
            res_valid_q <= 1'b1;
            cu_req_q    <= 1'b0;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          res_valid_q <= 1'b0;
          cu_req_q    <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relm_div_sequencer.sv
// Bench for relm_div_sequencer with a behavioural relm_custom divide model and the
// multiplier feedback loop closed through cu_mul_ax.
module tb_relm_div_sequencer;

  localparam int WD  = 32;
  localparam int WOP = 5;
  localparam int WC  = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WD-1:0]    req_n, req_d;
  logic             res_valid;
  logic             res_ready;
  logic [WD-1:0]    res_q, res_r;
  logic             res_dz;
  logic             cu_req;
  logic             cu_gnt;
  logic [WOP-1:0]   cu_op;
  logic             cu_opb;
  logic [WD-1:0]    cu_x, cu_a, cu_xb;
  logic [WC+WD-1:0] cu_cb;
  logic [WD-1:0]    u_a;
  logic [WC+WD-1:0] u_cb;
  logic [WD-1:0]    m_a, m_x;
  logic [2*WD-1:0]  cu_mul_ax;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  relm_div_sequencer #(.WD(WD), .WOP(WOP), .WC(WC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n     (req_n),
    .req_d     (req_d),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_q     (res_q),
    .res_r     (res_r),
    .res_dz    (res_dz),
    .cu_req    (cu_req),
    .cu_gnt    (cu_gnt),
    .cu_op     (cu_op),
    .cu_opb    (cu_opb),
    .cu_x      (cu_x),
    .cu_a      (cu_a),
    .cu_xb     (cu_xb),
    .cu_cb     (cu_cb),
    .cu_a_out  (u_a),
    .cu_cb_out (u_cb),
    .cu_mul_a  (m_a),
    .cu_mul_x  (m_x),
    .cu_mul_ax (cu_mul_ax)
  );

  logic [1:0] sub_w;
  assign sub_w = cu_x[WOP+1:WOP];

  function automatic logic [WD-1:0] msb1h(input logic [WD-1:0] v);
    msb1h = '0;
    for (int i = 0; i < WD; i++) if (v[i]) msb1h = WD'(1) << i;
  endfunction

  // Unit model: multiplier operands for DIVINIT (D * q0).
  always_comb begin
    m_a = '0;
    m_x = '0;
    if (cu_opb && sub_w == 2'b10) begin
      m_a = cu_cb[WC+WD-1 -: WD];
      m_x = cu_a;
    end
  end

  // Unit model: DIV gives MSB one-hots, DIVLOOP retires two quotient bits, DIVMOD returns C.
  always_comb begin
    logic [WD-1:0] aa, dq, cc, qq;
    aa   = cu_a;
    dq   = cu_cb[WC+WD-1 -: WD];
    cc   = cu_cb[WD +: WD];
    qq   = cu_cb[WD-1:0];
    u_a  = cu_a;
    u_cb = cu_cb;
    if (!cu_opb) begin
      u_a  = msb1h(cu_a);
      u_cb = {cu_xb, cu_a, msb1h(cu_xb)};
    end else begin
      case (sub_w)
        2'b10: u_cb = {cu_mul_ax[WD-1:0], cc, {WD{1'b0}}};
        2'b01: begin
          for (int k = 0; k < 2; k++) begin
            if (aa != '0) begin
              if (cc >= dq) begin
                cc = cc - dq;
                qq = qq | aa;
              end
              aa = aa >> 1;
              dq = dq >> 1;
            end
          end
          u_a  = aa;
          u_cb = {dq, cc, qq};
        end
        2'b11: u_a = cc;
        default: ;
      endcase
    end
  end

  // Step counters and hold-stability watcher, sampled mid-cycle.
  int n_div = 0, n_init = 0, n_loop = 0, n_mod = 0, n_req = 0, n_unstable = 0;
  logic             held_prev = 1'b0;
  logic [WOP+1+3*WD+WC+WD-1:0] snap = '0;
  always @(negedge clk) begin
    if (cu_req && cu_gnt) begin
      if (!cu_opb) n_div <= n_div + 1;
      else if (sub_w == 2'b10) n_init <= n_init + 1;
      else if (sub_w == 2'b01) n_loop <= n_loop + 1;
      else if (sub_w == 2'b11) n_mod <= n_mod + 1;
    end
    if (cu_req) n_req <= n_req + 1;
    if (held_prev && ({cu_op, cu_opb, cu_x, cu_a, cu_xb, cu_cb} !== snap))
      n_unstable <= n_unstable + 1;
    held_prev <= cu_req && !cu_gnt;
    snap      <= {cu_op, cu_opb, cu_x, cu_a, cu_xb, cu_cb};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic [WD-1:0] n, input logic [WD-1:0] d);
    int g;
    g = 0;
    while (!req_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    req_n = n; req_d = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input bit toggle, output int lat);
    lat = 1;
    while (!res_valid && lat < 300) begin
      if (toggle) cu_gnt = ~cu_gnt;
      @(posedge clk); #1; lat++;
    end
    cu_gnt = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b_div, b_init, b_loop, b_mod, b_req, b_uns, g;
    rst = 1'b1; req_valid = 1'b0; req_n = '0; req_d = '0; res_ready = 1'b1; cu_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_cu_req",    cu_req,    0);
    chk("rst_res_q",     res_q,     0);
    chk("rst_res_dz",    res_dz,    0);
    chk("rst_cu_cb",     cu_cb,     0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 100/7, continuous grant
    b_loop = n_loop; b_init = n_init; b_mod = n_mod;
    start_req(32'd100, 32'd7); wait_res(1'b0, lat);
    chk("d100_7_q", res_q, 14);
    chk("d100_7_r", res_r, 2);
    chk("d100_7_dz", res_dz, 0);
    chk("d100_7_lat", lat, 7);
    chk("d100_7_loops", n_loop - b_loop, 3);
    chk("d100_7_init", n_init - b_init, 1);
    chk("d100_7_mod", n_mod - b_mod, 1);

    // all-ones / 1
    b_loop = n_loop;
    start_req(32'hFFFF_FFFF, 32'd1); wait_res(1'b0, lat);
    chk("dmax_1_q", res_q, 32'hFFFF_FFFF);
    chk("dmax_1_r", res_r, 0);
    chk("dmax_1_loops", n_loop - b_loop, 16);
    chk("dmax_1_lat", lat, 20);

    // equal operands: pn == pd, one loop
    b_loop = n_loop;
    start_req(32'd7, 32'd7); wait_res(1'b0, lat);
    chk("d7_7_q", res_q, 1);
    chk("d7_7_r", res_r, 0);
    chk("d7_7_loops", n_loop - b_loop, 1);

    // 1000/10 -> 100 r 0, pn-pd = 6 -> 4 loops
    b_loop = n_loop;
    start_req(32'd1000, 32'd10); wait_res(1'b0, lat);
    chk("d1000_10_q", res_q, 100);
    chk("d1000_10_r", res_r, 0);
    chk("d1000_10_loops", n_loop - b_loop, 4);

    // 5/9: early exit after DIV
    b_div = n_div; b_init = n_init; b_loop = n_loop; b_mod = n_mod;
    start_req(32'd5, 32'd9); wait_res(1'b0, lat);
    chk("d5_9_q", res_q, 0);
    chk("d5_9_r", res_r, 5);
    chk("d5_9_lat", lat, 2);
    chk("d5_9_div", n_div - b_div, 1);
    chk("d5_9_nosteps", (n_init - b_init) + (n_loop - b_loop) + (n_mod - b_mod), 0);

    // 0/5: zero dividend takes the same early exit
    start_req(32'd0, 32'd5); wait_res(1'b0, lat);
    chk("d0_5_q", res_q, 0);
    chk("d0_5_r", res_r, 0);

    // 1234/0: divide by zero, no unit traffic
    b_req = n_req;
    start_req(32'd1234, 32'd0); wait_res(1'b0, lat);
    chk("dz_q", res_q, 32'hFFFF_FFFF);
    chk("dz_r", res_r, 1234);
    chk("dz_flag", res_dz, 1);
    chk("dz_lat", lat, 1);
    chk("dz_no_cu_req", n_req - b_req, 0);

    // 100/7 with alternating grant
    b_uns = n_unstable; b_loop = n_loop;
    start_req(32'd100, 32'd7); wait_res(1'b1, lat);
    chk("tgl_done", res_valid, 1);
    chk("tgl_q", res_q, 14);
    chk("tgl_r", res_r, 2);
    chk("tgl_dz", res_dz, 0);
    chk("tgl_loops", n_loop - b_loop, 3);
    chk("tgl_stable", n_unstable - b_uns, 0);

    // back-pressure on the result; a new request must be ignored
    res_ready = 1'b0;
    start_req(32'd100, 32'd7); wait_res(1'b0, lat);
    b_req = n_req; b_div = n_div;
    for (int i = 0; i < 5; i++) begin
      req_n = 32'd9; req_d = 32'd3; req_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_q", res_q, 14);
      chk("hold_r", res_r, 2);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_valid", res_valid, 0);
    chk("rel_req_ready", req_ready, 1);
    chk("rel_q", res_q, 14);
    chk("hold_no_cu_req", n_req - b_req, 0);
    chk("hold_no_div", n_div - b_div, 0);

    // reset pulse during LOOP
    b_loop = n_loop;
    start_req(32'hFFFF_FFFF, 32'd1);
    g = 0;
    while ((n_loop - b_loop) < 2 && g < 50) begin
      @(posedge clk); #1; g++;
    end
    chk("rst_in_loop_reached", cu_opb && (sub_w == 2'b01), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_cu_req", cu_req, 0);
    chk("mid_rst_res_q", res_q, 0);
    chk("mid_rst_res_r", res_r, 0);
    chk("mid_rst_cu_a", cu_a, 0);
    chk("mid_rst_cu_cb", cu_cb, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_result", res_valid, 0);
    start_req(32'd100, 32'd7); wait_res(1'b0, lat);
    chk("after_rst_q", res_q, 14);
    chk("after_rst_r", res_r, 2);
    chk("after_rst_lat", lat, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
